// File: rtl/kb_div3_serial_divider_pkg.sv
// Shared constants and types for the digit-serial divide-by-3 unit.
package kb_div3_pkg;

  localparam int SIZE_DEFAULT = 20;
  localparam int DIGIT_BITS   = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef logic [1:0] rem_t;

endpackage

// File: rtl/kb_div3_serial_divider_if.sv
// Load/result bundle between a requester (master) and the divide-by-3 unit (slave).
interface kb_div3_serial_divider_if #(
  parameter int SIZE = kb_div3_pkg::SIZE_DEFAULT
);

  logic               shift_en;
  logic [SIZE-1:0]    divident;
  logic [SIZE-1:0]    quotient;
  kb_div3_pkg::rem_t  reminder;
  logic               busy;
  logic               done;

  modport master (
    output shift_en, divident,
    input  quotient, reminder, busy, done
  );

  modport slave (
    input  shift_en, divident,
    output quotient, reminder, busy, done
  );

endinterface

// File: rtl/kb_div3_serial_divider_bit_cell.sv
// One restoring step of the mod-3 reduction: t = 2r + b, q = (t >= 3), r' = t mod 3.
module kb_div3_bit_cell
  import kb_div3_pkg::*;
(
  input  rem_t r_i,
  input  logic b_i,
  output logic q_o,
  output rem_t r_o
);

  // Quotient bit and next remainder from current remainder and incoming dividend bit
  always_comb begin
    q_o = 1'b0;
    r_o = 2'd0;
    case ({r_i, b_i})
      3'b000: begin q_o = 1'b0; r_o = 2'd0; end
      3'b001: begin q_o = 1'b0; r_o = 2'd1; end
      3'b010: begin q_o = 1'b0; r_o = 2'd2; end
      3'b011: begin q_o = 1'b1; r_o = 2'd0; end
      3'b100: begin q_o = 1'b1; r_o = 2'd1; end
      3'b101: begin q_o = 1'b1; r_o = 2'd2; end
      // r_i == 3 is unreachable; fold it to a legal remainder
      default: begin q_o = 1'b0; r_o = 2'd0; end
    endcase
  end

endmodule

// File: rtl/kb_div3_serial_divider.sv
// MSB-first digit-serial divide-by-3, DIGIT_BITS dividend bits per clock.
// Optional embedded checks are compiled in with KB_DIV3_ASSERT_EN.
module kb_div3_serial_divider
  import kb_div3_pkg::*;
#(
  parameter int SIZE = SIZE_DEFAULT
) (
  input  logic                      sys_clock,
  input  logic                      reset_n,
  kb_div3_serial_divider_if.slave   bus
);

  localparam int STEPS = SIZE / DIGIT_BITS;
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  state_e            state_q,    state_d;
  logic [SIZE-1:0]   div_sr_q,   div_sr_d;
  logic [SIZE-1:0]   quo_sr_q,   quo_sr_d;
  rem_t              r_q,        r_d;
  logic [CNT_W-1:0]  step_q,     step_d;
  logic [SIZE-1:0]   quotient_q, quotient_d;
  rem_t              reminder_q, reminder_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;

  rem_t                  r_chain_s [0:DIGIT_BITS];
  logic [DIGIT_BITS-1:0] q_bits_s;
  logic [SIZE-1:0]       quo_next_s;

  assign r_chain_s[0] = r_q;

  // Cell i consumes dividend bit SIZE-1-i, so the chain walks the top digit MSB first
  for (genvar i = 0; i < DIGIT_BITS; i++) begin : g_cell
    kb_div3_bit_cell u_cell (
      .r_i (r_chain_s[i]),
      .b_i (div_sr_q[SIZE-1-i]),
      .q_o (q_bits_s[DIGIT_BITS-1-i]),
      .r_o (r_chain_s[i+1])
    );
  end

  assign quo_next_s = (quo_sr_q << DIGIT_BITS) | SIZE'(q_bits_s);

  // State and datapath registers with synchronous active-high reset
  always_ff @(posedge sys_clock) begin
    if (reset_n) begin
      state_q    <= ST_IDLE;
      div_sr_q   <= '0;
      quo_sr_q   <= '0;
      r_q        <= 2'd0;
      step_q     <= '0;
      quotient_q <= '0;
      reminder_q <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_sr_q   <= div_sr_d;
      quo_sr_q   <= quo_sr_d;
      r_q        <= r_d;
      step_q     <= step_d;
      quotient_q <= quotient_d;
      reminder_q <= reminder_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic; a load strobe always wins, which also aborts a running operation
  always_comb begin
    state_d    = state_q;
    div_sr_d   = div_sr_q;
    quo_sr_d   = quo_sr_q;
    r_d        = r_q;
    step_d     = step_q;
    quotient_d = quotient_q;
    reminder_d = reminder_q;
    done_d     = 1'b0;

    if (bus.shift_en) begin
      state_d  = ST_RUN;
      div_sr_d = bus.divident;
      quo_sr_d = '0;
      r_d      = 2'd0;
      step_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_RUN: begin
          div_sr_d = div_sr_q << DIGIT_BITS;
          quo_sr_d = quo_next_s;
          r_d      = r_chain_s[DIGIT_BITS];
          step_d   = step_q + CNT_W'(1);
          if (step_q == LAST_STEP) begin
            state_d    = ST_IDLE;
            quotient_d = quo_next_s;
            reminder_d = r_chain_s[DIGIT_BITS];
            done_d     = 1'b1;
          end else begin
            state_d    = ST_RUN;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d == ST_RUN);
  end

  assign bus.quotient = quotient_q;
  assign bus.reminder = reminder_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

`ifdef KB_DIV3_ASSERT_EN
  logic [SIZE-1:0] latched_q;

  // Copy of the operand currently being divided, for the result identity check
  always_ff @(posedge sys_clock) begin
    if (reset_n) begin
      latched_q <= '0;
    end else if (bus.shift_en) begin
      latched_q <= bus.divident;
    end else begin
      latched_q <= latched_q;
    end
  end

  a_rem_legal: assert property (@(posedge sys_clock) disable iff (reset_n)
    reminder_q != 2'd3);

  a_result_ok: assert property (@(posedge sys_clock) disable iff (reset_n)
    done_q |-> (({2'b00, quotient_q} * (SIZE+2)'(3)) + (SIZE+2)'(reminder_q))
               == {2'b00, latched_q});

  a_done_pulse: assert property (@(posedge sys_clock) disable iff (reset_n)
    done_q |=> !done_q);
`endif

endmodule

// File: tb/tb_kb_div3_serial_divider.sv
// Scoreboard bench for kb_div3_serial_divider: expected results queued at load, compared on done.
module tb_kb_div3_serial_divider;

  localparam int SIZE = 20;

  typedef struct packed {
    logic [SIZE-1:0] q;
    logic [1:0]      r;
  } exp_t;

  logic clk;
  logic rst;

  kb_div3_serial_divider_if #(.SIZE(SIZE)) bus ();

  kb_div3_serial_divider #(.SIZE(SIZE)) dut (
    .sys_clock (clk),
    .reset_n   (rst),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks;
  int   n_errors;
  int   done_cnt;
  bit   inflight;
  exp_t exp_q[$];
  exp_t last_exp;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // Result monitor: pops the scoreboard on every done pulse
  always @(posedge clk) begin
    #1;
    if (bus.done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_done", 32'd1, 32'd0);
      end else begin
        last_exp = exp_q.pop_front();
        check_eq("quotient", 32'(bus.quotient), 32'(last_exp.q));
        check_eq("reminder", 32'(bus.reminder), 32'(last_exp.r));
        inflight = 1'b0;
      end
    end
  end

  task automatic load(input logic [SIZE-1:0] x);
    exp_t e;
    @(negedge clk);
    bus.shift_en = 1'b1;
    bus.divident = x;
    if (inflight && exp_q.size() != 0) void'(exp_q.pop_back());
    e.q = x / 20'd3;
    e.r = 2'(x % 20'd3);
    exp_q.push_back(e);
    inflight = 1'b1;
    @(negedge clk);
    bus.shift_en = 1'b0;
    bus.divident = 20'($urandom_range(0, 32'hFFFFF));
  endtask

  task automatic load_timed(input logic [SIZE-1:0] x);
    load(x);
    check_eq("busy_after_load", 32'(bus.busy), 32'd1);
    repeat (4) begin
      @(negedge clk);
      check_eq("busy_mid", 32'(bus.busy), 32'd1);
      check_eq("done_early", 32'(bus.done), 32'd0);
    end
    @(negedge clk);
    check_eq("done_at_5", 32'(bus.done), 32'd1);
    check_eq("busy_at_done", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check_eq("done_one_cycle", 32'(bus.done), 32'd0);
  endtask

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int d0;
    n_checks = 0;
    n_errors = 0;
    done_cnt = 0;
    inflight = 1'b0;
    rst = 1'b1;
    bus.shift_en = 1'b0;
    bus.divident = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_quotient", 32'(bus.quotient), 32'd0);
    check_eq("rst_reminder", 32'(bus.reminder), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    rst = 1'b0;

    load_timed(20'd9);
    repeat (3) @(negedge clk);
    check_eq("hold_quotient", 32'(bus.quotient), 32'd3);
    check_eq("hold_reminder", 32'(bus.reminder), 32'd0);

    load(20'd10);
    repeat (4) @(negedge clk);
    load(20'd2);
    repeat (4) @(negedge clk);
    load(20'hFFFFF);
    repeat (4) @(negedge clk);
    load(20'hFFFFE);
    repeat (4) @(negedge clk);
    load(20'd0);
    wait_empty(20);

    d0 = done_cnt;
    load(20'd100);
    load_timed(20'd7);
    check_eq("abort_single_done", 32'(done_cnt - d0), 32'd1);
    check_eq("abort_quotient", 32'(bus.quotient), 32'd2);
    check_eq("abort_reminder", 32'(bus.reminder), 32'd1);

    load(20'd12345);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    inflight = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_quotient", 32'(bus.quotient), 32'd0);
    check_eq("midrst_reminder", 32'(bus.reminder), 32'd0);
    check_eq("midrst_busy", 32'(bus.busy), 32'd0);
    check_eq("midrst_done", 32'(bus.done), 32'd0);
    repeat (8) @(negedge clk);
    check_eq("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    load_timed(20'd30);
    check_eq("post_rst_quotient", 32'(bus.quotient), 32'd10);

    for (int i = 0; i < 64; i++) begin
      load(20'($urandom_range(0, 32'hFFFFF)));
      repeat (4) @(negedge clk);
    end
    wait_empty(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/kb_div3_serial_divider.md
KB_DIV3_SERIAL_DIVIDER -- requirements
Module: kb_div3_serial_divider

Interface
REQ-001 SIZE, default 20, dividend/quotient width in bits; SHALL be a multiple of 4.
REQ-002 sys_clock  input  1  sole clock; all state SHALL change on its rising edge.
REQ-003 reset_n  input  1  reset, synchronous and active-high (asserted = 1).
REQ-004 shift_en  input  1  load strobe; one-cycle pulse starts a division of divident.
REQ-005 divident  input  SIZE  unsigned dividend, sampled only on the edge where shift_en=1.
REQ-006 quotient  output  SIZE  registered floor(divident/3) of the last completed operation.
REQ-007 reminder  output  2  registered divident mod 3 of the last completed operation, range 0..2.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse when quotient/reminder update.

Function
REQ-010 Algorithm SHALL be MSB-first digit-serial mod-3 reduction, 4 dividend bits per clock, SIZE/4 clocks per operation (5 for SIZE=20).
REQ-011 Per-bit cell SHALL compute t=2r+b; q_bit=(t>=3); r_next=t mod 3; r starts at 0.
REQ-012 Cell table (r,b -> q,r'): 0,0->0,0; 0,1->0,1; 1,0->0,2; 1,1->1,0; 2,0->1,1; 2,1->1,2.
REQ-013 Four cells SHALL be chained combinationally each cycle; the dividend shift register SHALL shift left 4, quotient shift register SHALL shift in the 4 q_bits.
REQ-014 FSM states IDLE and RUN; IDLE->RUN on shift_en=1; RUN->IDLE after SIZE/4 processing edges.
REQ-015 Timing: shift_en sampled 1 at edge k loads operands and clears r/step counter; processing edges k+1..k+SIZE/4; quotient/reminder/done update at edge k+SIZE/4.
REQ-016 busy SHALL be 1 from the cycle after load through the cycle before done; done high exactly one cycle.
REQ-017 shift_en=1 while busy SHALL abort the current operation and restart with the new divident; no done for the aborted one.
REQ-018 quotient/reminder SHALL hold their values between completions; divident changes while busy SHALL have no effect.
REQ-019 reminder SHALL never take the value 3.

Reset
REQ-020 reset_n=1 at a rising edge SHALL force IDLE, quotient=0, reminder=0, busy=0, done=0, clear internal registers.
REQ-021 Reset SHALL take priority over shift_en; reset mid-operation SHALL discard it with no done pulse.

Configuration
REQ-022 Macro KB_DIV3_ASSERT_EN: when defined, embedded SVA checks SHALL be compiled in (reminder<3; quotient*3+reminder equals latched dividend on done; done one cycle wide); when undefined, no assertion code, identical RTL behaviour.

Structure
REQ-023 Package kb_div3_pkg SHALL hold SIZE default, DIGIT_BITS=4, the FSM state enum, and the 2-bit remainder type.
REQ-024 One sub-module kb_div3_bit_cell SHALL implement REQ-011/012; top instantiates four in a chain.

Verification
REQ-025 Load 20'd9 -> after 5 cycles quotient=3, reminder=0, done pulse.
REQ-026 Load 20'd10 then 20'd2 (6 cycles apart) -> 3/1 then 0/2.
REQ-027 Load 20'hFFFFF -> 349525/0; load 20'hFFFFE -> 349524/2; load 0 -> 0/0.
REQ-028 Load 20'd100, re-pulse shift_en with 20'd7 two cycles later -> single done with 2/1 five cycles after second load.
REQ-029 Assert reset_n=1 mid-operation -> outputs 0, no done, next load works.
REQ-030 64 random dividends, pulse every 6 cycles -> every result matches floor(x/3), x mod 3.
